// File: rtl/fetch_issue_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_issue_ctrl
//   Front-end fetch sequencer. Owns the fetch PC, issues one icache request at
//   a time, and buffers fetched words with their PC and branch prediction in an
//   in-order queue whose head is presented to the decoder. Fetch is redirected
//   by RoB mispredict clears (highest priority) or by decoder jumps taken from
//   the queue head. A 2-bit-counter BHT supplies predictions for B-type words.
//
// Ports
//   clk_in, rst_in (sync, active-low), rdy_in (low = freeze everything)
//   icache_req_valid/addr   : one-cycle fetch request at the fetch PC
//   icache_resp_valid/inst  : one-cycle response for the outstanding request
//   fetch_ready/inst/pc/pred_res : queue head towards the decoder
//   issue_ready             : decoder consumes the head this cycle
//   pc_change_flag/pc_change: decoder redirect
//   rob_clear/rob_clear_pc  : RoB mispredict flush
//   bht_upd_valid/pc/taken  : committed branch outcome for the BHT
// -----------------------------------------------------------------------------
module fetch_issue_ctrl #(
    parameter int          DEPTH    = 4,
    parameter int          BHT_BITS = 6,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    output logic        icache_req_valid,
    output logic [31:0] icache_req_addr,
    input  logic        icache_resp_valid,
    input  logic [31:0] icache_resp_inst,
    output logic        fetch_ready,
    output logic [31:0] inst,
    output logic [31:0] pc,
    output logic        pred_res,
    input  logic        issue_ready,
    input  logic        pc_change_flag,
    input  logic [31:0] pc_change,
    input  logic        rob_clear,
    input  logic [31:0] rob_clear_pc,
    input  logic        bht_upd_valid,
    input  logic [31:0] bht_upd_pc,
    input  logic        bht_upd_taken
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;
    localparam int BHT_N = 1 << BHT_BITS;
    localparam logic [PTR_W-1:0] PTR_ONE = 1;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        S_IDLE,  // free to issue a request
        S_WAIT,  // request outstanding, response will be enqueued
        S_DROP   // request outstanding on a stale path, response discarded
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [31:0]      r_fetch_pc;
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [31:0]      r_q_inst [DEPTH];
    logic [31:0]      r_q_pc   [DEPTH];
    logic             r_q_pred [DEPTH];
    logic [1:0]       r_bht    [BHT_N];
    logic [31:0]      r_last_inst;
    logic [31:0]      r_last_pc;
    logic             r_last_pred;

    logic             w_empty;
    logic             w_full;
    logic [IDX_W-1:0] w_head_idx;
    logic [IDX_W-1:0] w_tail_idx;
    logic             w_redirect;
    logic [31:0]      w_target;
    logic             w_deq;
    logic             w_enq;
    logic             w_req;
    logic             w_pred;
    logic [BHT_BITS-1:0] w_lookup_idx;
    logic [BHT_BITS-1:0] w_upd_idx;
    logic             w_unused;

    assign w_head_idx = r_head[IDX_W-1:0];
    assign w_tail_idx = r_tail[IDX_W-1:0];
    assign w_empty    = (r_head == r_tail);
    // Same slot but different lap bit means the tail has lapped the head.
    assign w_full     = (r_head[IDX_W] != r_tail[IDX_W]) && (w_head_idx == w_tail_idx);

    // A decoder redirect only counts when the head is really being issued.
    assign w_redirect = rob_clear || (pc_change_flag && issue_ready && !w_empty);
    assign w_target   = rob_clear ? rob_clear_pc : pc_change;
    assign w_deq      = issue_ready && !w_empty && !rob_clear;
    // A response that meets a redirect is wrong-path and never enters the queue.
    assign w_enq      = (r_state == S_WAIT) && icache_resp_valid && !w_redirect;
    // Only one request in flight, so the queue needs one free slot at issue.
    assign w_req      = (r_state == S_IDLE) && !w_redirect && !w_full && rdy_in && rst_in;

    assign w_lookup_idx = r_fetch_pc[BHT_BITS+1:2];
    assign w_upd_idx    = bht_upd_pc[BHT_BITS+1:2];
    // The lookup reads the registered counter, so a same-cycle update is not seen.
    assign w_pred       = (icache_resp_inst[6:0] == OPC_BRANCH) && r_bht[w_lookup_idx][1];
    assign w_unused     = ^{bht_upd_pc[31:BHT_BITS+2], bht_upd_pc[1:0]};

    // NOTE: every signal written here gets a default first; otherwise a path
    // that skips the assignment would infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_req) w_state_nxt = S_WAIT;
            S_WAIT: begin
                if (icache_resp_valid) w_state_nxt = S_IDLE;
                else if (w_redirect)   w_state_nxt = S_DROP;
            end
            S_DROP:  if (icache_resp_valid) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_state     <= S_IDLE;
            r_fetch_pc  <= RESET_PC;
            r_head      <= '0;
            r_tail      <= '0;
            r_last_inst <= '0;
            r_last_pc   <= '0;
            r_last_pred <= 1'b0;
        end else if (rdy_in) begin
            r_state <= w_state_nxt;
            if (w_redirect) begin
                r_fetch_pc <= w_target;
                r_head     <= '0;
                r_tail     <= '0;
            end else begin
                if (w_enq) begin
                    r_fetch_pc <= r_fetch_pc + 32'd4;
                    r_tail     <= r_tail + PTR_ONE;
                end
                if (w_deq) r_head <= r_head + PTR_ONE;
            end
            // Remember the visible head so the outputs can hold once the queue drains.
            if (!w_empty) begin
                r_last_inst <= r_q_inst[w_head_idx];
                r_last_pc   <= r_q_pc[w_head_idx];
                r_last_pred <= r_q_pred[w_head_idx];
            end
        end
    end

    // NOTE: queue storage has no reset; the pointers alone decide which slots
    // are valid, so clearing the data would only add reset fan-out.
    always_ff @(posedge clk_in) begin
        if (rst_in && rdy_in && w_enq) begin
            r_q_inst[w_tail_idx] <= icache_resp_inst;
            r_q_pc[w_tail_idx]   <= r_fetch_pc;
            r_q_pred[w_tail_idx] <= w_pred;
        end
    end

    // BHT counters start weakly not-taken and saturate at 00 / 11.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            for (int i = 0; i < BHT_N; i++) r_bht[i] <= 2'b01;
        end else if (rdy_in && bht_upd_valid) begin
            if (bht_upd_taken && r_bht[w_upd_idx] != 2'b11)
                r_bht[w_upd_idx] <= r_bht[w_upd_idx] + 2'b01;
            else if (!bht_upd_taken && r_bht[w_upd_idx] != 2'b00)
                r_bht[w_upd_idx] <= r_bht[w_upd_idx] - 2'b01;
        end
    end

    assign icache_req_valid = w_req;
    assign icache_req_addr  = r_fetch_pc;
    assign fetch_ready      = !w_empty;
    assign inst             = w_empty ? r_last_inst : r_q_inst[w_head_idx];
    assign pc               = w_empty ? r_last_pc   : r_q_pc[w_head_idx];
    assign pred_res         = w_empty ? r_last_pred : r_q_pred[w_head_idx];

endmodule

// File: tb/tb_fetch_issue_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fetch_issue_ctrl
//   Directed bench for fetch_issue_ctrl. A small icache model answers each
//   request one cycle later when auto_ic is set; otherwise responses are driven
//   by hand. Expected values are worked out by hand from the fetch protocol.
// -----------------------------------------------------------------------------
module tb_fetch_issue_ctrl;

    logic        clk;
    logic        rst_in;
    logic        rdy_in;
    logic        icache_req_valid;
    logic [31:0] icache_req_addr;
    logic        icache_resp_valid;
    logic [31:0] icache_resp_inst;
    logic        fetch_ready;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        pred_res;
    logic        issue_ready;
    logic        pc_change_flag;
    logic [31:0] pc_change;
    logic        rob_clear;
    logic [31:0] rob_clear_pc;
    logic        bht_upd_valid;
    logic [31:0] bht_upd_pc;
    logic        bht_upd_taken;

    logic        auto_ic;
    int          checks;
    int          errors;

    localparam logic [31:0] INST_B  = 32'h00208463;  // beq
    localparam logic [31:0] INST_OP = 32'h00000013;  // addi (nop)

    fetch_issue_ctrl #(.DEPTH(4), .BHT_BITS(6), .RESET_PC(32'h0)) dut (
        .clk_in            (clk),
        .rst_in            (rst_in),
        .rdy_in            (rdy_in),
        .icache_req_valid  (icache_req_valid),
        .icache_req_addr   (icache_req_addr),
        .icache_resp_valid (icache_resp_valid),
        .icache_resp_inst  (icache_resp_inst),
        .fetch_ready       (fetch_ready),
        .inst              (inst),
        .pc                (pc),
        .pred_res          (pred_res),
        .issue_ready       (issue_ready),
        .pc_change_flag    (pc_change_flag),
        .pc_change         (pc_change),
        .rob_clear         (rob_clear),
        .rob_clear_pc      (rob_clear_pc),
        .bht_upd_valid     (bht_upd_valid),
        .bht_upd_pc        (bht_upd_pc),
        .bht_upd_taken     (bht_upd_taken)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Non-branch word whose upper bits encode its address.
    function automatic logic [31:0] imem(input logic [31:0] a);
        return {a[24:0], 7'h13};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock; leaves time at negedge+1 with the icache model updated.
    task automatic tick();
        logic        lr;
        logic [31:0] la;
        logic        rs;
        logic        rd;
        lr = icache_req_valid;
        la = icache_req_addr;
        rs = rst_in;
        rd = rdy_in;
        @(posedge clk);
        @(negedge clk);
        if (!rs) begin
            icache_resp_valid = 1'b0;
        end else if (auto_ic && rd) begin
            icache_resp_valid = lr;
            icache_resp_inst  = imem(la);
        end
        #1;
    endtask

    task automatic do_reset();
        rst_in = 1'b0;           rdy_in = 1'b1;
        icache_resp_valid = 1'b0; icache_resp_inst = '0;
        issue_ready = 1'b0;      pc_change_flag = 1'b0; pc_change = '0;
        rob_clear = 1'b0;        rob_clear_pc = '0;
        bht_upd_valid = 1'b0;    bht_upd_pc = '0;       bht_upd_taken = 1'b0;
        auto_ic = 1'b0;
        #1;
        tick();
        tick();
        chk("rst_req", icache_req_valid, 1'b0);
        chk("rst_fready", fetch_ready, 1'b0);
        chk("rst_inst", inst, 32'h0);
        chk("rst_pc", pc, 32'h0);
        chk("rst_pred", pred_res, 1'b0);
        rst_in = 1'b1;
        #1;
    endtask

    initial begin
        #400000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          nreq;
        logic [31:0] last_a;
        checks = 0;
        errors = 0;

        // 1: streaming fetch, one request every two cycles, heads in order.
        do_reset();
        issue_ready = 1'b1; auto_ic = 1'b1; #1;
        chk("s1_req_c0", icache_req_valid, 1'b1);
        chk("s1_addr_c0", icache_req_addr, 32'h0);
        tick();
        chk("s1_req_c1", icache_req_valid, 1'b0);
        tick();
        for (int k = 0; k < 3; k++) begin
            chk("s1_fready", fetch_ready, 1'b1);
            chk("s1_head_pc", pc, 32'(4 * k));
            chk("s1_head_inst", inst, imem(32'(4 * k)));
            chk("s1_req", icache_req_valid, 1'b1);
            chk("s1_addr", icache_req_addr, 32'(4 * k + 4));
            tick();
            chk("s1_drain", fetch_ready, 1'b0);
            tick();
        end

        // 2: no issue -> exactly DEPTH words fetched, then one more after a dequeue.
        do_reset();
        auto_ic = 1'b1; #1;
        nreq = 0; last_a = '0;
        for (int i = 0; i < 12; i++) begin
            if (icache_req_valid) begin
                nreq++;
                last_a = icache_req_addr;
            end
            tick();
        end
        chk("s2_nreq", 32'(nreq), 32'd4);
        chk("s2_last_addr", last_a, 32'hC);
        chk("s2_full_head", pc, 32'h0);
        issue_ready = 1'b1; #1;
        chk("s2_full_noreq", icache_req_valid, 1'b0);
        tick();
        issue_ready = 1'b0; #1;
        chk("s2_req_after_deq", icache_req_valid, 1'b1);
        chk("s2_addr_after_deq", icache_req_addr, 32'h10);
        chk("s2_head_after_deq", pc, 32'h4);
        tick();
        tick();
        chk("s2_full_again", icache_req_valid, 1'b0);

        // 3: decoder jump from head pc 8 with a request outstanding.
        do_reset();
        issue_ready = 1'b1; auto_ic = 1'b1; #1;
        repeat (6) tick();
        issue_ready = 1'b0; #1;
        chk("s3_head_pc8", pc, 32'h8);
        chk("s3_req12", icache_req_addr, 32'hC);
        auto_ic = 1'b0;
        tick();
        issue_ready = 1'b1; pc_change_flag = 1'b1; pc_change = 32'h40; #1;
        chk("s3_wait_noreq", icache_req_valid, 1'b0);
        tick();
        issue_ready = 1'b0; pc_change_flag = 1'b0;
        icache_resp_valid = 1'b1; icache_resp_inst = imem(32'hC); #1;
        chk("s3_flushed", fetch_ready, 1'b0);
        chk("s3_drop_noreq", icache_req_valid, 1'b0);
        chk("s3_hold_pc", pc, 32'h8);
        chk("s3_hold_inst", inst, imem(32'h8));
        tick();
        icache_resp_valid = 1'b0; #1;
        chk("s3_stale_dropped", fetch_ready, 1'b0);
        chk("s3_req_target", icache_req_valid, 1'b1);
        chk("s3_addr_target", icache_req_addr, 32'h40);

        // 4: rob_clear beats a same-cycle decoder jump and response.
        do_reset();
        auto_ic = 1'b1; #1;
        tick();
        tick();
        chk("s4_head_pc0", pc, 32'h0);
        chk("s4_req4", icache_req_addr, 32'h4);
        auto_ic = 1'b0;
        tick();
        icache_resp_valid = 1'b1; icache_resp_inst = imem(32'h4);
        rob_clear = 1'b1; rob_clear_pc = 32'h100;
        pc_change_flag = 1'b1; pc_change = 32'h40; issue_ready = 1'b1; #1;
        chk("s4_redirect_noreq", icache_req_valid, 1'b0);
        tick();
        icache_resp_valid = 1'b0; rob_clear = 1'b0;
        pc_change_flag = 1'b0; issue_ready = 1'b0; #1;
        chk("s4_flushed", fetch_ready, 1'b0);
        chk("s4_req", icache_req_valid, 1'b1);
        chk("s4_addr", icache_req_addr, 32'h100);
        auto_ic = 1'b1;
        tick();
        tick();
        chk("s4_head_pc", pc, 32'h100);

        // 5: BHT training and prediction at pc 0x20.
        do_reset();
        rob_clear = 1'b1; rob_clear_pc = 32'h20;
        bht_upd_valid = 1'b1; bht_upd_pc = 32'h20; bht_upd_taken = 1'b1; #1;
        tick();
        rob_clear = 1'b0; #1;
        chk("s5_req", icache_req_addr, 32'h20);
        tick();
        icache_resp_valid = 1'b1; icache_resp_inst = INST_B; #1;
        tick();
        icache_resp_valid = 1'b0;
        bht_upd_taken = 1'b0; rob_clear = 1'b1; #1;
        chk("s5_taken_inst", inst, INST_B);
        chk("s5_taken_pred", pred_res, 1'b1);
        tick();
        rob_clear = 1'b0; #1;
        chk("s5_refetch", icache_req_addr, 32'h20);
        tick();
        bht_upd_valid = 1'b0;
        icache_resp_valid = 1'b1; icache_resp_inst = INST_B; #1;
        tick();
        icache_resp_valid = 1'b0; #1;
        chk("s5_nt_fready", fetch_ready, 1'b1);
        chk("s5_nt_pred", pred_res, 1'b0);
        rob_clear = 1'b1; bht_upd_valid = 1'b1; bht_upd_taken = 1'b1; #1;
        tick();
        rob_clear = 1'b0; #1;
        tick();
        bht_upd_valid = 1'b0;
        icache_resp_valid = 1'b1; icache_resp_inst = INST_OP; #1;
        tick();
        icache_resp_valid = 1'b0; #1;
        chk("s5_nonbr_inst", inst, INST_OP);
        chk("s5_nonbr_pred", pred_res, 1'b0);
        // Counter is 11; bring it to 10, then look up during a not-taken update.
        rob_clear = 1'b1; bht_upd_valid = 1'b1; bht_upd_taken = 1'b0; #1;
        tick();
        rob_clear = 1'b0; bht_upd_valid = 1'b0; #1;
        tick();
        bht_upd_valid = 1'b1;
        icache_resp_valid = 1'b1; icache_resp_inst = INST_B; #1;
        tick();
        bht_upd_valid = 1'b0; icache_resp_valid = 1'b0; #1;
        chk("s5_preupd_pred", pred_res, 1'b1);

        // 6: rdy_in freeze with a request outstanding, then reset mid-WAIT.
        do_reset();
        auto_ic = 1'b1; #1;
        chk("s6_req0", icache_req_valid, 1'b1);
        tick();
        rdy_in = 1'b0; #1;
        for (int i = 0; i < 5; i++) begin
            chk("s6_frozen_fready", fetch_ready, 1'b0);
            chk("s6_frozen_req", icache_req_valid, 1'b0);
            tick();
        end
        rdy_in = 1'b1; #1;
        tick();
        chk("s6_after_fready", fetch_ready, 1'b1);
        chk("s6_after_pc", pc, 32'h0);
        chk("s6_after_addr", icache_req_addr, 32'h4);
        tick();
        auto_ic = 1'b0; icache_resp_valid = 1'b0; rst_in = 1'b0; #1;
        chk("s6_rst_req", icache_req_valid, 1'b0);
        tick();
        rst_in = 1'b1; #1;
        chk("s6_rst_fready", fetch_ready, 1'b0);
        chk("s6_rst_req_again", icache_req_valid, 1'b1);
        chk("s6_rst_addr", icache_req_addr, 32'h0);

        // 7: fetch PC wraps from 0xFFFFFFFC to 0.
        do_reset();
        auto_ic = 1'b1; rob_clear = 1'b1; rob_clear_pc = 32'hFFFF_FFFC; #1;
        tick();
        rob_clear = 1'b0; #1;
        chk("s7_addr_top", icache_req_addr, 32'hFFFF_FFFC);
        tick();
        tick();
        chk("s7_head_top", pc, 32'hFFFF_FFFC);
        chk("s7_addr_wrap", icache_req_addr, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
